// File: rtl/input_buffer_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : input_buffer_pkg                                              |
// | Description: Shared sizes, FSM encoding and lane helpers for the           |
// |              systolic-array input buffer read-side controller.             |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package input_buffer_pkg;

  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // Row-count ceiling expressed in the width of the num_rows port
  localparam logic [AW:0] DEPTH_ROWS = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Extract lane idx from a full buffer row
  function automatic logic [DW-1:0] lane_slice(input logic [LANES*DW-1:0] row, input int idx);
    return row[DW*idx +: DW];
  endfunction

  // Requests larger than the buffer read every row exactly once
  function automatic logic [AW:0] clamp_rows(input logic [AW:0] n);
    return (n > DEPTH_ROWS) ? DEPTH_ROWS : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : skew_delay_line                                               |
// | Description: DELAY-stage data+valid shift register; DELAY=0 passes through.|
// |              Reports whether any non-output stage still holds valid data.  |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module skew_delay_line #(
  parameter int DW    = 32,
  parameter int DELAY = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          pending
);

  generate
    if (DELAY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = CLK & RESET;
      assign out_data  = in_data;
      assign out_valid = in_valid;
      assign pending   = 1'b0;
    end else begin : g_delay
      logic [DW-1:0]    data_sr [DELAY];
      logic [DELAY-1:0] valid_sr;

      // Shift data and valid one stage per cycle; reset discards contents
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          for (int s = 0; s < DELAY; s++) data_sr[s] <= '0;
          valid_sr <= '0;
        end else begin
          data_sr[0]  <= in_data;
          valid_sr[0] <= in_valid;
          for (int s = 1; s < DELAY; s++) begin
            data_sr[s]  <= data_sr[s-1];
            valid_sr[s] <= valid_sr[s-1];
          end
        end
      end

      assign out_data  = data_sr[DELAY-1];
      assign out_valid = valid_sr[DELAY-1];

      // The output stage itself is not "pending": it is already visible
      if (DELAY == 1) begin : g_single
        assign pending = 1'b0;
      end else begin : g_multi
        assign pending = |valid_sr[DELAY-2:0];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/input_buffer_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : input_buffer_reader                                           |
// | Description: Reads N consecutive input-buffer rows (wrapping) and presents |
// |              them as a diagonally skewed wavefront, lane i delayed i.      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module input_buffer_reader
  import input_buffer_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW:0]         num_rows,
  output logic                busy,
  output logic                done,
  output logic                buf_CEN,
  output logic                buf_WEN,
  output logic                buf_RETN,
  output logic [AW-1:0]       buf_A,
  input  logic [LANES*DW-1:0] buf_Q,
  output logic [LANES*DW-1:0] lane_data,
  output logic [LANES-1:0]    lane_valid
);

  state_t              state;
  state_t              next_state;
  logic [AW-1:0]       addr_cnt;
  logic [AW:0]         rows_left;
  logic [AW:0]         rows_clamped;
  logic                rd_pend;
  logic [LANES*DW-1:0] stage0;
  logic                stage0_valid;
  logic [LANES-1:0]    lane_pending;
  logic                drain_empty;

  assign rows_clamped = clamp_rows(num_rows);
  assign drain_empty  = !rd_pend && !stage0_valid && !(|lane_pending);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign buf_WEN      = 1'b1;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a zero-row request passes through DRAIN (already empty)
  // so its done pulse lands two cycles after acceptance
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = (rows_clamped != '0) ? ST_READ : ST_DRAIN;
      ST_READ:  if (rows_left == '0) next_state = ST_DRAIN;
      ST_DRAIN: if (drain_empty) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Address issue: first row on acceptance, then one row per cycle in READ
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      buf_CEN   <= 1'b1;
      buf_A     <= '0;
      addr_cnt  <= '0;
      rows_left <= '0;
    end else begin
      buf_CEN <= 1'b1;
      if (state == ST_IDLE && start && rows_clamped != '0) begin
        buf_CEN   <= 1'b0;
        buf_A     <= base_addr;
        addr_cnt  <= base_addr + AW'(1);
        rows_left <= rows_clamped - (AW+1)'(1);
      end else if (state == ST_READ && rows_left != '0) begin
        buf_CEN   <= 1'b0;
        buf_A     <= addr_cnt;
        addr_cnt  <= addr_cnt + AW'(1);
        rows_left <= rows_left - (AW+1)'(1);
      end
    end
  end

  // Retention enable, read-data tracking and stage-0 capture of buf_Q
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      buf_RETN     <= 1'b0;
      rd_pend      <= 1'b0;
      stage0       <= '0;
      stage0_valid <= 1'b0;
    end else begin
      buf_RETN     <= 1'b1;
      rd_pend      <= !buf_CEN;
      stage0       <= buf_Q;
      stage0_valid <= rd_pend;
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DW-1:0] lane_in;
      // Invalid slots carry zero so idle lanes read as zero
      assign lane_in = stage0_valid ? lane_slice(stage0, i) : '0;

      skew_delay_line #(
        .DW    (DW),
        .DELAY (i)
      ) u_skew (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_data   (lane_in),
        .in_valid  (stage0_valid),
        .out_data  (lane_data[DW*i +: DW]),
        .out_valid (lane_valid[i]),
        .pending   (lane_pending[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_input_buffer_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_input_buffer_reader                                        |
// | Description: Directed self-checking bench for input_buffer_reader.         |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_input_buffer_reader;
  import input_buffer_pkg::*;

  localparam int W = LANES*DW;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      num_rows;
  logic             busy, done, buf_CEN, buf_WEN, buf_RETN;
  logic [AW-1:0]    buf_A;
  logic [W-1:0]     buf_Q;
  logic [W-1:0]     lane_data;
  logic [LANES-1:0] lane_valid;

  logic [W-1:0]     mem [DEPTH];
  logic [W-1:0]     q_model;

  int n_checks = 0;
  int n_errors = 0;

  input_buffer_reader dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .busy       (busy),
    .done       (done),
    .buf_CEN    (buf_CEN),
    .buf_WEN    (buf_WEN),
    .buf_RETN   (buf_RETN),
    .buf_A      (buf_A),
    .buf_Q      (buf_Q),
    .lane_data  (lane_data),
    .lane_valid (lane_valid)
  );

  always #5 CLK = ~CLK;

  // Buffer macro model: data one cycle after a CEN=0 read, junk otherwise
  always @(posedge CLK) begin
    if (!buf_CEN) q_model <= mem[buf_A];
    else          q_model <= {LANES{32'hDEAD_BEEF}};
  end
  assign buf_Q = q_model;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, " busy"},  W'(busy),       W'(1'b0));
    check_eq({tag, " done"},  W'(done),       W'(1'b0));
    check_eq({tag, " cen"},   W'(buf_CEN),    W'(1'b1));
    check_eq({tag, " wen"},   W'(buf_WEN),    W'(1'b1));
    check_eq({tag, " retn"},  W'(buf_RETN),   W'(1'b0));
    check_eq({tag, " addr"},  W'(buf_A),      W'(0));
    check_eq({tag, " data"},  lane_data,      '0);
    check_eq({tag, " valid"}, W'(lane_valid), W'(0));
  endtask

  // Start a request in the current cycle t and check every cycle through t+done+1.
  // spur > 0 pulses start (with different base/rows) in that cycle of the run.
  task automatic run_op(input int base, input int nreq, input int spur);
    int n, done_c, last_c, k;
    int vcount [LANES];
    logic             exp_cen;
    logic [LANES-1:0] ev;
    logic [W-1:0]     ed;
    n      = (nreq > DEPTH) ? DEPTH : nreq;
    done_c = (n == 0) ? 2 : n + 18;
    last_c = done_c + 1;
    for (int i = 0; i < LANES; i++) vcount[i] = 0;
    base_addr = AW'(base);
    num_rows  = (AW+1)'(nreq);
    start     = 1'b1;
    tick();
    for (int c = 1; c <= last_c; c++) begin
      exp_cen = !(n > 0 && c <= n);
      check_eq($sformatf("b%0d n%0d c%0d busy", base, nreq, c), W'(busy), W'(c <= done_c));
      check_eq($sformatf("b%0d n%0d c%0d done", base, nreq, c), W'(done), W'(c == done_c));
      check_eq($sformatf("b%0d n%0d c%0d cen", base, nreq, c), W'(buf_CEN), W'(exp_cen));
      if (!exp_cen)
        check_eq($sformatf("b%0d n%0d c%0d addr", base, nreq, c), W'(buf_A), W'((base + c - 1) % DEPTH));
      check_eq($sformatf("b%0d n%0d c%0d wen", base, nreq, c), W'(buf_WEN), W'(1'b1));
      check_eq($sformatf("b%0d n%0d c%0d retn", base, nreq, c), W'(buf_RETN), W'(1'b1));
      ev = '0;
      ed = '0;
      for (int i = 0; i < LANES; i++) begin
        k = c - 3 - i;
        if (n > 0 && k >= 0 && k < n) begin
          ev[i] = 1'b1;
          ed[DW*i +: DW] = mem[(base + k) % DEPTH][DW*i +: DW];
        end
        if (lane_valid[i]) vcount[i]++;
      end
      check_eq($sformatf("b%0d n%0d c%0d valid", base, nreq, c), W'(lane_valid), W'(ev));
      check_eq($sformatf("b%0d n%0d c%0d data", base, nreq, c), lane_data, ed);
      start = (c == spur);
      if (c == 1 || c == spur) begin
        base_addr = AW'($urandom);
        num_rows  = (AW+1)'($urandom_range(1, 40));
      end
      if (c < last_c) tick();
    end
    start = 1'b0;
    for (int i = 0; i < LANES; i++)
      check_eq($sformatf("b%0d n%0d lane%0d vcount", base, nreq, i), W'(vcount[i]), W'(n));
  endtask

  initial begin
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    RESET     = 1'b1;
    for (int r = 0; r < DEPTH; r++)
      for (int i = 0; i < LANES; i++) mem[r][DW*i +: DW] = $urandom;
    for (int i = 0; i < LANES; i++) mem[0][DW*i +: DW] = 32'(32'h100 + i);

    // Power-on reset
    #2 RESET = 1'b0;
    #1 check_reset_values("por");
    tick();
    tick();
    check_reset_values("por held");
    #2 RESET = 1'b1;
    tick();
    check_eq("retn after release", W'(buf_RETN), W'(1'b1));
    tick();

    // Single row from base 0: lane i carries 0x100+i at t+3+i, done at t+19
    run_op(0, 1, 0);
    // Wrap from 30 through 0
    run_op(30, 4, 0);
    // Zero rows: no reads, done at t+2
    run_op(9, 0, 0);
    // Oversized request clamps to 32 reads, ignored start mid-run, back-to-back start
    run_op(17, 40, 5);
    run_op(5, 2, 0);

    // Reset in the middle of a read burst
    base_addr = AW'(2);
    num_rows  = (AW+1)'(8);
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_eq("pre-abort busy", W'(busy), W'(1'b1));
    check_eq("pre-abort lane0 valid", W'(lane_valid[0]), W'(1'b1));
    RESET = 1'b0;
    #1 check_reset_values("abort");
    tick();
    #2 RESET = 1'b1;
    tick();
    check_eq("abort retn", W'(buf_RETN), W'(1'b1));
    for (int c = 0; c < 24; c++) begin
      check_eq($sformatf("post-abort c%0d valid", c), W'(lane_valid), W'(0));
      check_eq($sformatf("post-abort c%0d cen", c), W'(buf_CEN), W'(1'b1));
      check_eq($sformatf("post-abort c%0d busy", c), W'(busy), W'(1'b0));
      tick();
    end
    run_op(3, 8, 0);

    // Full-depth read of fresh random contents from a random base
    for (int r = 0; r < DEPTH; r++)
      for (int i = 0; i < LANES; i++) mem[r][DW*i +: DW] = $urandom;
    run_op(int'($urandom_range(0, DEPTH-1)), 32, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
